// File: rtl/controle_envase_pkg.sv
// Shared bottling-line definitions: station FSM encoding and default line parameters.
// Imported by the station controllers and their sub-blocks.
package controle_envase_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVEY  = 3'd1,
    FILL    = 3'd2,
    TO_SEAL = 3'd3,
    SEAL    = 3'd4,
    COUNT   = 3'd5,
    ALARM   = 3'd6
  } estado_t;

  localparam int ROLHA_INIT_DEF   = 20;
  localparam int FILL_TIMEOUT_DEF = 15;
  localparam int DUZIA            = 12;

endpackage

// File: rtl/controle_envase_if.sv
// Operator, sensor and actuator bundle of the bottling station.
// master drives the operator/sensor side, slave is the station controller.
interface controle_envase_if;

  logic       start;
  logic       stop;
  logic       ack;
  logic       garrafa;
  logic       pos_enchimento;
  logic       nivel_cheio;
  logic       pos_vedacao;
  logic       repor;
  logic       ved_done;
  logic       ved_alarme;

  logic       motor;
  logic       valvula;
  logic       ved_req;
  logic [3:0] cont_garrafas;
  logic [4:0] estoque_rolhas;
  logic       duzia_pronta;
  logic       alarme_geral;

  modport master (
    output start, stop, ack, garrafa, pos_enchimento, nivel_cheio,
           pos_vedacao, repor, ved_done, ved_alarme,
    input  motor, valvula, ved_req, cont_garrafas, estoque_rolhas,
           duzia_pronta, alarme_geral
  );

  modport slave (
    input  start, stop, ack, garrafa, pos_enchimento, nivel_cheio,
           pos_vedacao, repor, ved_done, ved_alarme,
    output motor, valvula, ved_req, cont_garrafas, estoque_rolhas,
           duzia_pronta, alarme_geral
  );

endinterface

// File: rtl/contador_duzia.sv
// Modulo-12 bottle counter; pulse is high for the one cycle in which the count has
// just wrapped from 11 back to 0.
module contador_duzia
  import controle_envase_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] count,
  output logic       pulse
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (inc) begin
        if (count == 4'(DUZIA - 1)) begin
          count <= 4'd0;
          pulse <= 1'b1;
        end else begin
          count <= count + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/controle_envase.sv
// Bottling station controller: conveyor, filler and sealer sequencing with cork stock
// and dozen tracking. Define FILL_WATCHDOG_EN to alarm on a fill that never completes.
module controle_envase
  import controle_envase_pkg::*;
#(
  parameter int ROLHA_INIT   = ROLHA_INIT_DEF,
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              reset,
  controle_envase_if.slave bus
);

  estado_t    state, next_state;
  logic       stop_pend;
  logic       motor_r, valvula_r, ved_req_r, alarme_r;
  logic [4:0] estoque;
  logic       sem_rolha;
  logic       fill_expired;
  logic [3:0] cont;
  logic       duzia;

  assign sem_rolha = (estoque == 5'd0);

`ifdef FILL_WATCHDOG_EN
  localparam int TIMER_W = $clog2(FILL_TIMEOUT + 1);
  logic [TIMER_W-1:0] fill_timer;

  // Holds the number of FILL cycles already spent; zero whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              fill_timer <= '0;
    else if (state != FILL) fill_timer <= '0;
    else                    fill_timer <= fill_timer + 1'b1;
  end

  assign fill_expired = (fill_timer == TIMER_W'(FILL_TIMEOUT - 1));
`else
  logic unused_fill_timeout;
  assign fill_expired        = 1'b0;
  assign unused_fill_timeout = (FILL_TIMEOUT > 0);
`endif

  // NOTE: default assignment first so every path drives next_state and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = CONVEY;
      CONVEY: begin
        if (stop_pend)                             next_state = IDLE;
        else if (bus.garrafa && bus.pos_enchimento) next_state = FILL;
      end
      FILL: begin
        if (bus.nivel_cheio)   next_state = TO_SEAL;
        else if (fill_expired) next_state = ALARM;
      end
      TO_SEAL: if (bus.pos_vedacao) next_state = sem_rolha ? ALARM : SEAL;
      SEAL: begin
        if (bus.ved_alarme)    next_state = ALARM;
        else if (bus.ved_done) next_state = COUNT;
      end
      COUNT:   next_state = stop_pend ? IDLE : CONVEY;
      ALARM:   if (bus.ack && !bus.ved_alarme && !sem_rolha) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // Actuators are decoded from next_state so they are registered yet aligned with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
      motor_r   <= 1'b0;
      valvula_r <= 1'b0;
      ved_req_r <= 1'b0;
      alarme_r  <= 1'b0;
    end else begin
      state     <= next_state;
      stop_pend <= (next_state == IDLE) ? 1'b0 : (stop_pend | bus.stop);
      motor_r   <= (next_state == CONVEY) || (next_state == TO_SEAL);
      valvula_r <= (next_state == FILL);
      ved_req_r <= (next_state == SEAL);
      alarme_r  <= (next_state == ALARM);
    end
  end

  // A magazine refill overrides the decrement of a coincident COUNT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              estoque <= 5'(ROLHA_INIT);
    else if (bus.repor)                     estoque <= 5'(ROLHA_INIT);
    else if (state == COUNT && !sem_rolha)  estoque <= estoque - 5'd1;
  end

  contador_duzia u_contador_duzia (
    .clk   (clk),
    .reset (reset),
    .inc   (state == COUNT),
    .count (cont),
    .pulse (duzia)
  );

  assign bus.motor          = motor_r;
  assign bus.valvula        = valvula_r;
  assign bus.ved_req        = ved_req_r;
  assign bus.alarme_geral   = alarme_r;
  assign bus.cont_garrafas  = cont;
  assign bus.estoque_rolhas = estoque;
  assign bus.duzia_pronta   = duzia;

endmodule

// File: tb/tb_controle_envase.sv
// Self-checking bench for controle_envase: directed scenarios plus randomized bottle
// timing checked against a count/stock model; honours FILL_WATCHDOG_EN.
module tb_controle_envase;
  import controle_envase_pkg::*;

  logic clk;
  logic reset;
  logic reset2;
  int   passed;
  int   total;
  int   duzia_seen;
  int   model_cnt;
  int   model_stock;

  controle_envase_if bus ();
  controle_envase_if bus2 ();

  // The small-magazine instance follows the same operator/sensor stimulus.
  assign bus2.start          = bus.start;
  assign bus2.stop           = bus.stop;
  assign bus2.ack            = bus.ack;
  assign bus2.garrafa        = bus.garrafa;
  assign bus2.pos_enchimento = bus.pos_enchimento;
  assign bus2.nivel_cheio    = bus.nivel_cheio;
  assign bus2.pos_vedacao    = bus.pos_vedacao;
  assign bus2.repor          = bus.repor;
  assign bus2.ved_done       = bus.ved_done;
  assign bus2.ved_alarme     = bus.ved_alarme;

  controle_envase dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  controle_envase #(.ROLHA_INIT(2)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.duzia_pronta === 1'b1) duzia_seen <= duzia_seen + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1, "bench did not terminate");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs;
    bus.start = 0; bus.stop = 0; bus.ack = 0; bus.garrafa = 0; bus.pos_enchimento = 0;
    bus.nivel_cheio = 0; bus.pos_vedacao = 0; bus.repor = 0; bus.ved_done = 0; bus.ved_alarme = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    step(1);
    reset = 0;
  endtask

  // From CONVEY, one full bottle with the given sensor delays; ends in the cycle after COUNT.
  task automatic run_bottle(input int w_fill, input int w_level, input int w_seal,
                            input int w_done, input bit refill);
    step(w_fill);  bus.garrafa = 1; bus.pos_enchimento = 1; step(1);
    bus.garrafa = 0; bus.pos_enchimento = 0;
    step(w_level); bus.nivel_cheio = 1; step(1); bus.nivel_cheio = 0;
    step(w_seal);  bus.pos_vedacao = 1; step(1); bus.pos_vedacao = 0;
    step(w_done);  bus.ved_done = 1; step(1); bus.ved_done = 0;
    bus.repor = refill; step(1); bus.repor = 0;
  endtask

  // From IDLE to the first SEAL cycle.
  task automatic drive_to_seal;
    bus.start = 1; step(1); bus.start = 0;
    bus.garrafa = 1; bus.pos_enchimento = 1; step(1);
    bus.garrafa = 0; bus.pos_enchimento = 0;
    bus.nivel_cheio = 1; step(1); bus.nivel_cheio = 0;
    bus.pos_vedacao = 1; step(1); bus.pos_vedacao = 0;
  endtask

  task automatic test_reset;
    logic [4:0] outs;
    outs = {bus.motor, bus.valvula, bus.ved_req, bus.duzia_pronta, bus.alarme_geral};
    total++; if (outs !== 5'b0) $display("FAIL reset_outputs: got %b, expected 00000", outs); else passed++;
    total++; if (bus.cont_garrafas !== 4'd0) $display("FAIL reset_cont: got %0d, expected 0", bus.cont_garrafas); else passed++;
    total++; if (bus.estoque_rolhas !== 5'd20) $display("FAIL reset_estoque: got %0d, expected 20", bus.estoque_rolhas); else passed++;
    total++; if (dut.state !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", dut.state, IDLE); else passed++;
    total++; if (bus2.estoque_rolhas !== 5'd2) $display("FAIL reset_estoque_small: got %0d, expected 2", bus2.estoque_rolhas); else passed++;
    step(2);
    total++; if (bus.motor !== 1'b0) $display("FAIL idle_no_start: motor got %b, expected 0", bus.motor); else passed++;
  endtask

  task automatic test_first_bottle;
    bus.start = 1; step(1); bus.start = 0;
    total++; if (dut.state !== CONVEY || bus.motor !== 1'b1) $display("FAIL first_convey: state %0d motor %b, expected %0d 1", dut.state, bus.motor, CONVEY); else passed++;
    bus.garrafa = 1; bus.pos_enchimento = 1; step(1); bus.garrafa = 0; bus.pos_enchimento = 0;
    total++; if (dut.state !== FILL || bus.valvula !== 1'b1 || bus.motor !== 1'b0) $display("FAIL first_fill: state %0d valvula %b motor %b, expected %0d 1 0", dut.state, bus.valvula, bus.motor, FILL); else passed++;
    bus.nivel_cheio = 1; step(1); bus.nivel_cheio = 0;
    total++; if (dut.state !== TO_SEAL || bus.motor !== 1'b1 || bus.valvula !== 1'b0) $display("FAIL first_to_seal: state %0d motor %b valvula %b, expected %0d 1 0", dut.state, bus.motor, bus.valvula, TO_SEAL); else passed++;
    bus.pos_vedacao = 1; step(1); bus.pos_vedacao = 0;
    total++; if (dut.state !== SEAL || bus.ved_req !== 1'b1 || bus.motor !== 1'b0) $display("FAIL first_seal: state %0d ved_req %b motor %b, expected %0d 1 0", dut.state, bus.ved_req, bus.motor, SEAL); else passed++;
    bus.ved_done = 1; step(1); bus.ved_done = 0;
    total++; if (dut.state !== COUNT || bus.ved_req !== 1'b0) $display("FAIL first_count: state %0d ved_req %b, expected %0d 0", dut.state, bus.ved_req, COUNT); else passed++;
    step(1);
    total++; if (dut.state !== CONVEY) $display("FAIL first_back_convey: got %0d, expected %0d", dut.state, CONVEY); else passed++;
    total++; if (bus.cont_garrafas !== 4'd1) $display("FAIL first_cont: got %0d, expected 1", bus.cont_garrafas); else passed++;
    total++; if (bus.estoque_rolhas !== 5'd19) $display("FAIL first_estoque: got %0d, expected 19", bus.estoque_rolhas); else passed++;
  endtask

  task automatic test_dozen;
    int base;
    base = duzia_seen;
    for (int b = 0; b < 11; b++) run_bottle(0, 0, 0, 0, 1'b0);
    total++; if (bus.cont_garrafas !== 4'd0) $display("FAIL dozen_wrap: got %0d, expected 0", bus.cont_garrafas); else passed++;
    total++; if (bus.duzia_pronta !== 1'b1) $display("FAIL dozen_pulse: got %b, expected 1", bus.duzia_pronta); else passed++;
    total++; if (bus.estoque_rolhas !== 5'd8) $display("FAIL dozen_estoque: got %0d, expected 8", bus.estoque_rolhas); else passed++;
    step(1);
    total++; if (duzia_seen - base != 1) $display("FAIL dozen_pulse_width: got %0d cycles, expected 1", duzia_seen - base); else passed++;
  endtask

  task automatic test_random;
    do_reset;
    model_cnt   = 0;
    model_stock = 20;
    bus.start = 1; step(1); bus.start = 0;
    for (int b = 0; b < 30; b++) begin
      bit refill;
      bit exp_duzia;
      refill = ($urandom_range(0, 4) == 0) || (model_stock <= 2);
      run_bottle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), refill);
      model_cnt   = (model_cnt + 1) % 12;
      model_stock = refill ? 20 : model_stock - 1;
      exp_duzia   = (model_cnt == 0);
      total++; if (bus.cont_garrafas !== 4'(model_cnt)) $display("FAIL rand_cont[%0d]: got %0d, expected %0d", b, bus.cont_garrafas, model_cnt); else passed++;
      total++; if (bus.estoque_rolhas !== 5'(model_stock)) $display("FAIL rand_estoque[%0d]: got %0d, expected %0d", b, bus.estoque_rolhas, model_stock); else passed++;
      total++; if (bus.duzia_pronta !== exp_duzia) $display("FAIL rand_duzia[%0d]: got %b, expected %b", b, bus.duzia_pronta, exp_duzia); else passed++;
    end
  endtask

  task automatic test_stop;
    bus.garrafa = 1; bus.pos_enchimento = 1; step(1); bus.garrafa = 0; bus.pos_enchimento = 0;
    bus.stop = 1; step(1); bus.stop = 0;
    step(2);
    total++; if (dut.state !== FILL || bus.valvula !== 1'b1) $display("FAIL stop_fill_kept: state %0d valvula %b, expected %0d 1", dut.state, bus.valvula, FILL); else passed++;
    bus.nivel_cheio = 1; step(1); bus.nivel_cheio = 0;
    bus.pos_vedacao = 1; step(1); bus.pos_vedacao = 0;
    bus.ved_done = 1; step(1); bus.ved_done = 0;
    total++; if (dut.state !== COUNT) $display("FAIL stop_count: got %0d, expected %0d", dut.state, COUNT); else passed++;
    step(1);
    model_cnt   = (model_cnt + 1) % 12;
    model_stock = model_stock - 1;
    total++; if (dut.state !== IDLE || bus.motor !== 1'b0) $display("FAIL stop_idle: state %0d motor %b, expected %0d 0", dut.state, bus.motor, IDLE); else passed++;
    total++; if (bus.cont_garrafas !== 4'(model_cnt)) $display("FAIL stop_cont: got %0d, expected %0d", bus.cont_garrafas, model_cnt); else passed++;
  endtask

  task automatic test_seal_alarm;
    drive_to_seal;
    total++; if (bus.ved_req !== 1'b1) $display("FAIL salarm_seal: ved_req got %b, expected 1", bus.ved_req); else passed++;
    bus.ved_alarme = 1; bus.ved_done = 1; step(1); bus.ved_done = 0;
    total++; if (bus.alarme_geral !== 1'b1 || bus.ved_req !== 1'b0 || bus.motor !== 1'b0) $display("FAIL salarm_enter: alarme %b ved_req %b motor %b, expected 1 0 0", bus.alarme_geral, bus.ved_req, bus.motor); else passed++;
    step(1);
    total++; if (bus.cont_garrafas !== 4'(model_cnt)) $display("FAIL salarm_cont: got %0d, expected %0d", bus.cont_garrafas, model_cnt); else passed++;
    total++; if (bus.estoque_rolhas !== 5'(model_stock)) $display("FAIL salarm_estoque: got %0d, expected %0d", bus.estoque_rolhas, model_stock); else passed++;
    bus.ack = 1; step(1);
    total++; if (bus.alarme_geral !== 1'b1) $display("FAIL salarm_ack_fault_active: alarme got %b, expected 1", bus.alarme_geral); else passed++;
    bus.ved_alarme = 0; step(1); bus.ack = 0;
    total++; if (bus.alarme_geral !== 1'b0 || dut.state !== IDLE) $display("FAIL salarm_exit: alarme %b state %0d, expected 0 %0d", bus.alarme_geral, dut.state, IDLE); else passed++;
  endtask

  task automatic test_rolha_limit;
    reset2 = 0;
    bus.start = 1; step(1); bus.start = 0;
    run_bottle(0, 0, 0, 0, 1'b0);
    run_bottle(1, 0, 1, 0, 1'b0);
    total++; if (bus2.estoque_rolhas !== 5'd0 || bus2.cont_garrafas !== 4'd2) $display("FAIL rolha_drained: estoque %0d cont %0d, expected 0 2", bus2.estoque_rolhas, bus2.cont_garrafas); else passed++;
    bus.garrafa = 1; bus.pos_enchimento = 1; step(1); bus.garrafa = 0; bus.pos_enchimento = 0;
    bus.nivel_cheio = 1; step(1); bus.nivel_cheio = 0;
    bus.pos_vedacao = 1; step(1); bus.pos_vedacao = 0;
    total++; if (bus2.alarme_geral !== 1'b1 || bus2.ved_req !== 1'b0) $display("FAIL rolha_alarm: alarme %b ved_req %b, expected 1 0", bus2.alarme_geral, bus2.ved_req); else passed++;
    step(3);
    total++; if (bus2.ved_req !== 1'b0 || bus2.motor !== 1'b0) $display("FAIL rolha_no_seal: ved_req %b motor %b, expected 0 0", bus2.ved_req, bus2.motor); else passed++;
    bus.ack = 1; step(1); bus.ack = 0; step(1);
    total++; if (bus2.alarme_geral !== 1'b1) $display("FAIL rolha_ack_alone: alarme got %b, expected 1", bus2.alarme_geral); else passed++;
    bus.repor = 1; step(1); bus.repor = 0;
    total++; if (bus2.estoque_rolhas !== 5'd2 || bus2.alarme_geral !== 1'b1) $display("FAIL rolha_refill: estoque %0d alarme %b, expected 2 1", bus2.estoque_rolhas, bus2.alarme_geral); else passed++;
    bus.ack = 1; step(1); bus.ack = 0;
    total++; if (bus2.alarme_geral !== 1'b0 || dut2.state !== IDLE) $display("FAIL rolha_exit: alarme %b state %0d, expected 0 %0d", bus2.alarme_geral, dut2.state, IDLE); else passed++;
    total++; if (bus2.estoque_rolhas !== 5'd2) $display("FAIL rolha_exit_estoque: got %0d, expected 2", bus2.estoque_rolhas); else passed++;
  endtask

  task automatic test_repor_count;
    do_reset;
    bus.start = 1; step(1); bus.start = 0;
    run_bottle(1, 1, 1, 1, 1'b0);
    total++; if (bus.estoque_rolhas !== 5'd19) $display("FAIL repor_pre: got %0d, expected 19", bus.estoque_rolhas); else passed++;
    run_bottle(0, 2, 0, 1, 1'b1);
    total++; if (bus.estoque_rolhas !== 5'd20) $display("FAIL repor_count_wins: got %0d, expected 20", bus.estoque_rolhas); else passed++;
    total++; if (bus.cont_garrafas !== 4'd2) $display("FAIL repor_cont: got %0d, expected 2", bus.cont_garrafas); else passed++;
  endtask

  task automatic test_watchdog;
    int fill_cycles;
    bit alarmed;
    do_reset;
    bus.start = 1; step(1); bus.start = 0;
    bus.garrafa = 1; bus.pos_enchimento = 1; step(1); bus.garrafa = 0; bus.pos_enchimento = 0;
    total++; if (bus.valvula !== 1'b1) $display("FAIL wd_fill_entry: valvula got %b, expected 1", bus.valvula); else passed++;
`ifdef FILL_WATCHDOG_EN
    fill_cycles = 1;
    alarmed     = 1'b0;
    for (int i = 0; i < 120 && !alarmed; i++) begin
      step(1);
      if (bus.valvula === 1'b1) fill_cycles++;
      if (bus.alarme_geral === 1'b1) alarmed = 1'b1;
    end
    total++; if (!alarmed) $display("FAIL wd_alarm: got no alarm in 120 cycles, expected alarm"); else passed++;
    total++; if (fill_cycles != 15) $display("FAIL wd_fill_length: got %0d cycles, expected 15", fill_cycles); else passed++;
    total++; if (bus.valvula !== 1'b0) $display("FAIL wd_valve_closed: got %b, expected 0", bus.valvula); else passed++;
`else
    fill_cycles = 0;
    alarmed     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.valvula === 1'b1) fill_cycles++;
      if (bus.alarme_geral === 1'b1) alarmed = 1'b1;
    end
    total++; if (fill_cycles != 100 || dut.state !== FILL) $display("FAIL nowd_fill_persist: got %0d cycles state %0d, expected 100 %0d", fill_cycles, dut.state, FILL); else passed++;
    total++; if (alarmed) $display("FAIL nowd_no_alarm: got alarm, expected none"); else passed++;
`endif
  endtask

  task automatic test_reset_mid_seal;
    do_reset;
    drive_to_seal;
    total++; if (bus.ved_req !== 1'b1) $display("FAIL rseal_seal: ved_req got %b, expected 1", bus.ved_req); else passed++;
    #2 reset = 1;
    #1;
    total++; if (bus.ved_req !== 1'b0 || dut.state !== IDLE) $display("FAIL rseal_async: ved_req %b state %0d, expected 0 %0d", bus.ved_req, dut.state, IDLE); else passed++;
    total++; if (bus.estoque_rolhas !== 5'd20 || bus.cont_garrafas !== 4'd0) $display("FAIL rseal_counters: estoque %0d cont %0d, expected 20 0", bus.estoque_rolhas, bus.cont_garrafas); else passed++;
    step(1);
    reset = 0;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    duzia_seen = 0;
    reset      = 1;
    reset2     = 1;
    clear_inputs;
    step(2);
    test_reset;
    reset = 0;
    step(1);
    test_first_bottle;
    test_dozen;
    test_random;
    test_stop;
    test_seal_alarm;
    test_rolha_limit;
    test_repor_count;
    test_watchdog;
    test_reset_mid_seal;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
